// File: rtl/seven_sd_pkg.sv
// ---------------------------------------------------------------------------
// seven_sd_pkg
// Shared constants and helpers for the seven-segment scan driver.
//   NUM_DIGITS / SEG_BITS / BRIGHT_BITS : display geometry and PWM depth
//   DIGIT_W                             : width of the digit index
//   slot_cnt_width()                    : width of the in-slot cycle counter
//   seg_all_off() / en_all_off()        : "everything dark" pin patterns
// ---------------------------------------------------------------------------
package seven_sd_pkg;

    localparam int NUM_DIGITS  = 4;
    localparam int SEG_BITS    = 8;
    localparam int BRIGHT_BITS = 3;
    localparam int WORD_BITS   = NUM_DIGITS * SEG_BITS;
    localparam int DIGIT_W     = $clog2(NUM_DIGITS);

    // Dark patterns for each pin polarity.
    localparam logic [SEG_BITS-1:0]   SEG_OFF_ACTIVE_LOW  = 8'hFF;
    localparam logic [SEG_BITS-1:0]   SEG_OFF_ACTIVE_HIGH = 8'h00;
    localparam logic [NUM_DIGITS-1:0] EN_OFF_ACTIVE_LOW   = 4'hF;
    localparam logic [NUM_DIGITS-1:0] EN_OFF_ACTIVE_HIGH  = 4'h0;

    typedef logic [DIGIT_W-1:0] digit_idx_t;

    function automatic int slot_cnt_width(input int slot_cycles);
        return $clog2(slot_cycles);
    endfunction

    function automatic logic [SEG_BITS-1:0] seg_all_off(input bit active_low);
        return active_low ? SEG_OFF_ACTIVE_LOW : SEG_OFF_ACTIVE_HIGH;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] en_all_off(input bit active_low);
        return active_low ? EN_OFF_ACTIVE_LOW : EN_OFF_ACTIVE_HIGH;
    endfunction

endpackage

// File: rtl/seven_sd_scan_driver_slot_timer.sv
// ---------------------------------------------------------------------------
// seven_sd_scan_driver_slot_timer
// Slot/digit counters for the scan driver.
//   clk, resetN : clock and asynchronous active-low reset
//   slotCnt     : cycle position inside the current digit slot
//   digitIdx    : digit currently being scanned (0,1,2,3,0,...)
//   slotStart   : high while slotCnt = 0
//   frameWrap   : high while slotCnt = 0 and digitIdx = 0
// ---------------------------------------------------------------------------
module seven_sd_scan_driver_slot_timer
    import seven_sd_pkg::*;
#(
    parameter int SLOT_CYCLES = 25000,
    parameter int CNT_W       = 15
) (
    input  logic             clk,
    input  logic             resetN,
    output logic [CNT_W-1:0] slotCnt,
    output digit_idx_t       digitIdx,
    output logic             slotStart,
    output logic             frameWrap
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_CYCLES - 1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            slotCnt  <= '0;
            digitIdx <= '0;
        end else if (slotCnt == LAST_CNT) begin
            slotCnt  <= '0;
            // Index is exactly DIGIT_W bits wide, so it wraps 3 -> 0 naturally.
            digitIdx <= digitIdx + 1'b1;
        end else begin
            slotCnt  <= slotCnt + 1'b1;
        end
    end

    assign slotStart = (slotCnt == '0);
    assign frameWrap = slotStart && (digitIdx == '0);

endmodule

// File: rtl/seven_sd_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_sd_scan_driver
// Time-multiplexes a packed 4-digit segment word onto a common-anode display
// with a frame shadow, an anti-ghosting guard interval and 8-level PWM.
//   clk, resetN : clock and asynchronous active-low reset
//   value       : segment word, byte d drives digit d, 1 = segment lit
//   brightness  : 0 = dimmest, 7 = full on-window
//   blank       : 1 forces all digit enables off
//   displayOut  : segment pins (polarity set by SEG_ACTIVE_LOW)
//   enableOut   : digit enable pins (polarity set by EN_ACTIVE_LOW)
//   frameStart  : one-cycle pulse when the shadow word loads
// ---------------------------------------------------------------------------
module seven_sd_scan_driver
    import seven_sd_pkg::*;
#(
    parameter int SLOT_CYCLES    = 25000,
    parameter int GUARD_CYCLES   = 200,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [WORD_BITS-1:0]   value,
    input  logic [BRIGHT_BITS-1:0] brightness,
    input  logic                   blank,
    output logic [SEG_BITS-1:0]    displayOut,
    output logic [NUM_DIGITS-1:0]  enableOut,
    output logic                   frameStart
);

    localparam int CNT_W = slot_cnt_width(SLOT_CYCLES);

    localparam logic [SEG_BITS-1:0]   SEG_OFF = seg_all_off(SEG_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] EN_OFF  = en_all_off(EN_ACTIVE_LOW);

    // One extra bit so GUARD + onLen never wraps, even when SLOT_CYCLES is a
    // power of two.
    localparam logic [CNT_W:0]   GUARD_X = (CNT_W+1)'(GUARD_CYCLES);
    // Usable slot length, widened by BRIGHT_BITS for the PWM product.
    localparam logic [CNT_W+2:0] SPAN    = (CNT_W+3)'(SLOT_CYCLES - GUARD_CYCLES);

    // onLen = (SPAN * (b+1)) >> 3; the product fits in CNT_W+3 bits since
    // b+1 <= 8 and SPAN < 2**CNT_W.
    function automatic logic [CNT_W-1:0] on_len(input logic [BRIGHT_BITS-1:0] b);
        logic [CNT_W+2:0] prod;
        prod = SPAN * {{CNT_W{1'b0}}, b} + SPAN;
        return prod[CNT_W+2:3];
    endfunction

    logic [CNT_W-1:0]                   slotCnt;
    digit_idx_t                         digitIdx;
    logic                               slotStart;
    logic                               frameWrap;

    logic [NUM_DIGITS-1:0][SEG_BITS-1:0] shadow;
    logic [NUM_DIGITS-1:0][SEG_BITS-1:0] frameWord;
    logic [BRIGHT_BITS-1:0]             brightReg;
    logic [BRIGHT_BITS-1:0]             brightEff;
    logic [CNT_W-1:0]                   onLen;
    logic [SEG_BITS-1:0]                segByte;
    logic [SEG_BITS-1:0]                segDrive;
    logic                               inWindow;
    logic [NUM_DIGITS-1:0]              oneHot;
    logic [NUM_DIGITS-1:0]              enActive;
    logic [NUM_DIGITS-1:0]              enDrive;

    seven_sd_scan_driver_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_slot_timer (
        .clk       (clk),
        .resetN    (resetN),
        .slotCnt   (slotCnt),
        .digitIdx  (digitIdx),
        .slotStart (slotStart),
        .frameWrap (frameWrap)
    );

    // The shadow loads on the same edge that digit 0's segments are driven,
    // so that edge must see the incoming word rather than the stale shadow.
    assign frameWord = frameWrap ? value : shadow;
    assign segByte   = frameWord[digitIdx];
    assign segDrive  = SEG_ACTIVE_LOW ? ~segByte : segByte;

    // brightReg is only written at slot start; bypass it on that cycle so a
    // zero-length guard still sees this slot's brightness.
    assign brightEff = slotStart ? brightness : brightReg;
    assign onLen     = on_len(brightEff);

    assign inWindow  = ({1'b0, slotCnt} >= GUARD_X) &&
                       ({1'b0, slotCnt} <  GUARD_X + {1'b0, onLen});

    assign oneHot    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digitIdx;
    assign enActive  = (inWindow && !blank) ? oneHot : '0;
    assign enDrive   = EN_ACTIVE_LOW ? ~enActive : enActive;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shadow     <= '0;
            brightReg  <= '0;
            displayOut <= SEG_OFF;
            enableOut  <= EN_OFF;
            frameStart <= 1'b0;
        end else begin
            frameStart <= frameWrap;
            enableOut  <= enDrive;
            if (slotStart) begin
                brightReg  <= brightness;
                displayOut <= segDrive;
                if (frameWrap) begin
                    shadow <= value;
                end
            end
        end
    end

endmodule
